// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and constants for the uart_tx round-robin scheduler.
// Optional CR->CRLF expansion is built when TX_CRLF_EN is defined.
package uart_tx_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_GAP
`ifdef TX_CRLF_EN
    , ST_LF
`endif
  } state_e;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  // Tie goes to the port not served last; otherwise the non-empty one.
  function automatic logic pick_port(
    input logic ne0,
    input logic ne1,
    input logic last
  );
    if (ne0 && ne1) return !last;
    return !ne0;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_fifo.sv
// Small byte FIFO with combinational head; one per requester port.
// Pushes while full are dropped, even in a cycle that also pops.
module byte_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam logic [FIFO_AW:0] CNT_FULL =
    (FIFO_AW+1)'(FIFO_DEPTH);

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one uart_tx between keyboard (port 0) and RX echo (port 1).
// Define TX_CRLF_EN to follow every transmitted CR with an unarbitrated LF.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  input  logic       tx_active,
  input  logic       tx_done,
  output logic       tx_wr,
  output logic [7:0] tx_byte,
  output logic       grant,
  output logic       busy
);

  state_e     state_q, state_d;
  logic       sel_q, sel_d;
  logic       last_q, last_d;
  logic       grant_q, grant_d;
  logic       tx_wr_q, tx_wr_d;
  logic [7:0] tx_byte_q, tx_byte_d;

  logic       pop0, pop1;
  logic       full0, full1;
  logic       empty0, empty1;
  logic [7:0] dout0, dout1;
  logic [7:0] head;

  byte_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .FIFO_AW   (FIFO_AW)
  ) u_fifo0 (
    .clk  (clk),
    .rst  (rst),
    .push (req0_valid),
    .din  (req0_data),
    .pop  (pop0),
    .dout (dout0),
    .full (full0),
    .empty(empty0)
  );

  byte_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .FIFO_AW   (FIFO_AW)
  ) u_fifo1 (
    .clk  (clk),
    .rst  (rst),
    .push (req1_valid),
    .din  (req1_data),
    .pop  (pop1),
    .dout (dout1),
    .full (full1),
    .empty(empty1)
  );

  assign head = sel_q ? dout1 : dout0;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    grant_d   = grant_q;
    tx_wr_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    pop0      = 1'b0;
    pop1      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!tx_active && (!empty0 || !empty1)) begin
          sel_d   = pick_port(!empty0, !empty1, last_q);
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        tx_wr_d   = 1'b1;
        tx_byte_d = head;
        pop0      = !sel_q;
        pop1      = sel_q;
        grant_d   = sel_q;
        last_d    = sel_q;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done) begin
`ifdef TX_CRLF_EN
          state_d = (tx_byte_q == CHAR_CR) ? ST_LF : ST_GAP;
`else
          state_d = ST_GAP;
`endif
        end
      end
      ST_GAP: state_d = ST_IDLE;
`ifdef TX_CRLF_EN
      // LF rides on the CR's grant; no pop, no arbitration.
      ST_LF: begin
        tx_wr_d   = 1'b1;
        tx_byte_d = CHAR_LF;
        state_d   = ST_WAIT;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= 1'b0;
      last_q    <= 1'b1;
      grant_q   <= 1'b0;
      tx_wr_q   <= 1'b0;
      tx_byte_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      tx_wr_q   <= tx_wr_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  assign req0_ready = !full0;
  assign req1_ready = !full1;
  assign tx_wr      = tx_wr_q;
  assign tx_byte    = tx_byte_q;
  assign grant      = grant_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler with a simple uart_tx model.
// Honours TX_CRLF_EN for the CR/LF scenario.
module tb_uart_tx_scheduler;

  localparam int FRAME = 10;

  logic       clk;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       tx_active, tx_done;
  logic       tx_wr, grant, busy;
  logic [7:0] tx_byte;

  logic model_active, model_done;
  logic hold_active, spur_done;
  assign tx_active = model_active | hold_active;
  assign tx_done   = model_done | spur_done;

  int total = 0;
  int bad   = 0;
  logic [8:0] sb[$];

  uart_tx_scheduler #(
    .FIFO_DEPTH(4),
    .FIFO_AW   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_data (req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_data (req1_data),
    .req1_ready(req1_ready),
    .tx_active (tx_active),
    .tx_done   (tx_done),
    .tx_wr     (tx_wr),
    .tx_byte   (tx_byte),
    .grant     (grant),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // uart_tx model: frame starts after a sampled tx_wr, ends with a 1-cycle done
  initial begin
    logic wr_seen;
    int   cnt;
    model_active = 1'b0;
    model_done   = 1'b0;
    cnt          = 0;
    forever begin
      @(negedge clk);
      wr_seen = (tx_wr === 1'b1);
      @(posedge clk);
      #1;
      model_done = 1'b0;
      if (wr_seen) begin
        model_active = 1'b1;
        cnt          = FRAME;
      end else if (model_active) begin
        if (cnt <= 1) begin
          model_active = 1'b0;
          model_done   = 1'b1;
        end else begin
          cnt--;
        end
      end
    end
  end

  // monitor: every start strobe must match the next scoreboard entry
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (tx_wr === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_tx_wr", {23'd0, grant, tx_byte}, 32'h1ff);
        end else begin
          e = sb.pop_front();
          chk("tx_byte", {24'd0, tx_byte}, {24'd0, e[7:0]});
          chk("grant", {31'd0, grant}, {31'd0, e[8]});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic push2(input logic v0, input logic [7:0] d0,
                       input logic v1, input logic [7:0] d1);
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    step(1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic expect_tx(input logic g, input logic [7:0] b);
    sb.push_back({g, b});
  endtask

  task automatic drain(input string name);
    int i;
    i = 0;
    while ((sb.size() != 0 || busy || tx_active) && i < 600) begin
      step(1);
      i++;
    end
    chk(name, {31'd0, (i < 600)}, 32'd1);
  endtask

  task automatic quiet(input string name, input int n);
    int wr_cnt;
    wr_cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (tx_wr) wr_cnt++;
      step(1);
    end
    chk(name, wr_cnt, 0);
  endtask

  initial begin
    rst         = 1'b1;
    req0_valid  = 1'b0;
    req1_valid  = 1'b0;
    req0_data   = 8'h00;
    req1_data   = 8'h00;
    hold_active = 1'b0;
    spur_done   = 1'b0;
    step(2);
    do_reset();

    chk("rst_tx_wr", {31'd0, tx_wr}, 32'd0);
    chk("rst_tx_byte", {24'd0, tx_byte}, 32'h00);
    chk("rst_grant", {31'd0, grant}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd3);

    // single byte, latency of two cycles
    expect_tx(1'b0, 8'h41);
    push2(1'b1, 8'h41, 1'b0, 8'h00);
    chk("lat_c0", {31'd0, tx_wr}, 32'd0);
    step(1);
    chk("lat_c1", {31'd0, tx_wr}, 32'd0);
    chk("lat_busy", {31'd0, busy}, 32'd1);
    step(1);
    chk("lat_c2", {31'd0, tx_wr}, 32'd1);
    chk("lat_byte", {24'd0, tx_byte}, 32'h41);
    step(3);
    chk("wait_busy", {31'd0, busy}, 32'd1);
    chk("hold_byte", {24'd0, tx_byte}, 32'h41);
    drain("t1_drain");
    chk("t1_idle", {31'd0, busy}, 32'd0);

    // simultaneous traffic alternates, port 0 first after reset
    do_reset();
    expect_tx(1'b0, 8'h10);
    expect_tx(1'b1, 8'h20);
    expect_tx(1'b0, 8'h11);
    expect_tx(1'b1, 8'h21);
    expect_tx(1'b0, 8'h12);
    expect_tx(1'b1, 8'h22);
    push2(1'b1, 8'h10, 1'b1, 8'h20);
    push2(1'b1, 8'h11, 1'b1, 8'h21);
    push2(1'b1, 8'h12, 1'b1, 8'h22);
    drain("t2_drain");

    // fill port 1 while the UART is held busy
    do_reset();
    hold_active = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_ready_pre", {31'd0, req1_ready}, 32'd1);
      push2(1'b0, 8'h00, 1'b1, 8'h30 + 8'(i));
      expect_tx(1'b1, 8'h30 + 8'(i));
    end
    chk("t3_full", {31'd0, req1_ready}, 32'd0);
    push2(1'b0, 8'h00, 1'b1, 8'h34);
    chk("t3_still_full", {31'd0, req1_ready}, 32'd0);
    chk("t3_no_send", {31'd0, busy}, 32'd0);
    hold_active = 1'b0;
    drain("t3_drain");

    // reset mid-frame flushes queued bytes
    do_reset();
    expect_tx(1'b0, 8'h40);
    push2(1'b1, 8'h40, 1'b0, 8'h00);
    push2(1'b1, 8'h41, 1'b0, 8'h00);
    push2(1'b1, 8'h42, 1'b0, 8'h00);
    for (int i = 0; i < 20 && !tx_active; i++) step(1);
    chk("t4_active", {31'd0, tx_active}, 32'd1);
    chk("t4_wait_busy", {31'd0, busy}, 32'd1);
    do_reset();
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_tx_byte", {24'd0, tx_byte}, 32'h00);
    chk("t4_ready", {30'd0, req0_ready, req1_ready}, 32'd3);
    quiet("t4_no_frames", 60);
    chk("t4_sb", sb.size(), 0);

    // CR handling
    do_reset();
`ifdef TX_CRLF_EN
    expect_tx(1'b0, 8'h0D);
    expect_tx(1'b0, 8'h0A);
    expect_tx(1'b1, 8'h55);
`else
    expect_tx(1'b0, 8'h0D);
    expect_tx(1'b1, 8'h55);
`endif
    push2(1'b1, 8'h0D, 1'b1, 8'h55);
    drain("t5_drain");

    // spurious tx_done while idle
    do_reset();
    spur_done = 1'b1;
    step(1);
    spur_done = 1'b0;
    chk("t6_busy", {31'd0, busy}, 32'd0);
    quiet("t6_no_wr", 10);
    chk("t6_busy_after", {31'd0, busy}, 32'd0);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
